// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: per-requester valid/ready byte handshake bundle
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    modport master (output req_valid, req_data, input req_ready);
    modport slave  (input req_valid, req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding one UART transmit line
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    uart_tx_scheduler_if.slave bus,
    output logic               tx,
    output logic               busy,
    output logic [ID_W-1:0]    grant_id
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   C_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   B_LAST  = BW'(DATA_BITS - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   ID_NUM  = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state, w_state;
    logic [ID_W-1:0]      r_ptr, w_ptr;
    logic [ID_W-1:0]      r_grant, w_grant;
    logic [BW-1:0]        r_bit, w_bit;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 r_tx, w_tx;
    logic                 r_busy, w_busy;
    logic [ID_W-1:0]      w_win;
    logic [ID_W:0]        w_idx;
    logic                 w_any;
    logic                 w_last;
    logic [CW-1:0]        w_cnt_nxt;

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign grant_id = r_grant;
    assign w_last    = r_cnt == C_LAST;
    assign w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
    assign bus.req_ready = (reset && r_state == IDLE && w_any) ? NUM_REQ'(1) << w_win : '0;

    // first valid requester at or above the pointer, wrapping; lowest offset wins
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (ID_W + 1)'(k);
            w_idx = (w_idx >= ID_NUM) ? w_idx - ID_NUM : w_idx;
            if (bus.req_valid[w_idx[ID_W-1:0]]) begin
                w_win = w_idx[ID_W-1:0];
                w_any = 1'b1;
            end
        end
    end

    // frame sequencing: next state and next register values
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_grant = r_grant;
        w_bit   = r_bit;
        w_cnt   = r_cnt;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_busy  = r_busy;
        case (r_state)
            IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (w_any) begin
                    w_shift = bus.req_data[w_win*DATA_BITS +: DATA_BITS];
                    w_grant = w_win;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                    w_cnt   = '0;
                    w_state = START;
                end
            end
            START: begin
                w_cnt = w_cnt_nxt;
                if (w_last) begin
                    w_tx    = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_bit   = '0;
                    w_state = DATA;
                end
            end
            DATA: begin
                w_cnt = w_cnt_nxt;
                if (w_last && r_bit == B_LAST) begin
                    w_tx    = 1'b1;
                    w_state = STOP;
                end else if (w_last) begin
                    w_tx    = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_bit   = r_bit + 1'b1;
                end
            end
            default: begin
                w_cnt = w_cnt_nxt;
                if (w_last) begin
                    w_busy  = 1'b0;
                    w_ptr   = (r_grant == ID_LAST) ? '0 : r_grant + 1'b1;
                    w_state = IDLE;
                end
            end
        endcase
    end

    // state register with synchronous active-low reset; aborts any frame in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_grant <= w_grant;
            r_bit   <= w_bit;
            r_cnt   <= w_cnt;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: random requests, transaction-level arbitration model, frame scoreboard
module tb_uart_tx_scheduler;
    localparam int N = 4;
    localparam int C = 8;
    localparam int D = 8;
    localparam int F = (D + 2) * C;

    typedef struct {
        int           id;
        logic [D-1:0] d;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_tx_scheduler_if #(.NUM_REQ(N), .DATA_BITS(D)) bus ();
    logic       tx, busy;
    logic [1:0] gid;
    uart_tx_scheduler #(.NUM_REQ(N), .CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
        .clock(clock), .reset(reset), .bus(bus), .tx(tx), .busy(busy), .grant_id(gid)
    );

    uart_tx_scheduler_if #(.NUM_REQ(2), .DATA_BITS(5)) bus1 ();
    logic tx1, busy1, gid1;
    uart_tx_scheduler #(.NUM_REQ(2), .CLKS_PER_BIT(1), .DATA_BITS(5)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .tx(tx1), .busy(busy1), .grant_id(gid1)
    );
    assign bus1.req_valid = 2'b01;
    assign bus1.req_data  = {5'h0A, 5'h13};

    int           total = 0, bad = 0;
    logic [N-1:0] pend = '0;
    logic [D-1:0] dat [N];
    int           ptr = 0;
    longint       cyc = 0, free_at = 0;
    exp_t         q [$];
    bit           abort = 1'b0;

    assign bus.req_valid = pend;
    for (genvar g = 0; g < N; g++) begin : g_data
        assign bus.req_data[g*D +: D] = dat[g];
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // one clock: model predicts the grant, then requesters update after the edge
    task automatic step(input logic [N-1:0] mask, input int prob);
        int           w;
        logic [N-1:0] er;
        @(negedge clock);
        w = -1;
        if (cyc >= free_at)
            for (int k = N - 1; k >= 0; k--)
                if (pend[(ptr + k) % N]) w = (ptr + k) % N;
        er = (w >= 0) ? N'(1) << w : '0;
        chk("req_ready", bus.req_ready, er);
        if (w >= 0) begin
            q.push_back('{w, dat[w]});
            free_at = cyc + F + 1;
            ptr = (w + 1) % N;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (w >= 0) pend[w] = 1'b0;
        for (int i = 0; i < N; i++)
            if (!pend[i]) begin
                dat[i] = D'($urandom);
                if (mask[i] && $urandom_range(99) < prob) pend[i] = 1'b1;
            end
    endtask

    task automatic drain();
        int t = 0;
        while ((pend != 0 || cyc < free_at + 1 || q.size() != 0) && t < 3000) begin
            step('0, 0);
            t++;
        end
        if (t >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain: got pending=%0h want idle", pend);
        end
    endtask

    // monitor: each busy rise is a frame, compared bit-by-bit against the queued byte
    initial begin
        bit   pb = 1'b0;
        exp_t e;
        int   s;
        logic eb;
        forever begin
            @(negedge clock);
            if (busy === 1'b1 && !pb && !abort) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame: got unexpected frame grant=%0d want none", gid);
                end else begin
                    e = q.pop_front();
                    chk("grant_id", gid, e.id);
                    for (int k = 0; k < F && !abort; k++) begin
                        if (k > 0) @(negedge clock);
                        s = k / C;
                        eb = (s == 0) ? 1'b0 : (s <= D ? e.d[s-1] : 1'b1);
                        if (!abort) begin
                            chk("busy_in_frame", busy, 1);
                            chk("tx_bit", tx, eb);
                        end
                    end
                    if (!abort) @(negedge clock);
                    if (!abort) begin
                        chk("busy_end", busy, 0);
                        chk("tx_idle", tx, 1);
                        chk("grant_hold", gid, e.id);
                    end
                end
            end
            pb = busy;
        end
    end

    // short-bit, 5-data-bit instance: fixed periodic frame of byte 0x13
    initial begin
        int           p;
        logic [6:0]   pat = 7'b1100110;
        do @(negedge clock); while (!reset);
        for (int j = 0; j < 40; j++) begin
            p = j % 8;
            chk("b_ready", bus1.req_ready, p == 0 ? 2'b01 : 2'b00);
            chk("b_busy", busy1, p != 0);
            chk("b_tx", tx1, p == 0 ? 1'b1 : pat[p-1]);
            chk("b_grant", gid1, 0);
            @(negedge clock);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // main sequence
    initial begin
        for (int i = 0; i < N; i++) dat[i] = D'($urandom);
        pend = '1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", gid, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_tx1", tx1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_ready1", bus1.req_ready, 0);
        @(posedge clock);
        #1;
        pend = 4'b0001;
        dat[0] = 8'hA5;
        reset = 1'b1;
        free_at = cyc;
        repeat (100) step('0, 0);
        drain();
        repeat (500) step(4'b1111, 100);
        drain();
        repeat (400) step(4'b1010, 100);
        drain();
        pend[0] = 1'b1;
        dat[0] = D'($urandom);
        repeat (21) step('0, 0);
        pend[2] = 1'b1;
        dat[2] = D'($urandom);
        drain();
        pend[0] = 1'b1;
        dat[0] = D'($urandom);
        step('0, 0);
        repeat (35) @(posedge clock);
        #1;
        abort = 1'b1;
        reset = 1'b0;
        pend[1] = 1'b1;
        dat[1] = D'($urandom);
        @(posedge clock);
        @(negedge clock);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", gid, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        abort = 1'b0;
        ptr = 0;
        free_at = cyc;
        repeat (150) step('0, 0);
        drain();
        repeat (3000) step(4'b1111, 3);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
